// File: rtl/dev_bus_arbiter.sv
// -----------------------------------------------------------------------------
// dev_bus_arbiter
//
// Shares the single device-bus port of the peripheral bridge between two
// requesters: M0 (CPU memory stage) and M1 (debug loader / DMA engine).
// Each transaction is IDLE -> XFER -> RESP, so the minimum is 3 cycles per
// transaction. The bridge only ever sees one master.
//
// Handshake: a requester raises mX_req with stable addr/wd/we and holds them
// until mX_ack. mX_ack is a one-cycle pulse carrying mX_err and mX_rd. The
// request is latched at the grant edge, so dropping req mid-transaction does
// not cancel it. A request still high after the ack is seen as a new request.
//
// Configuration macro:
//   ARB_FIXED_PRIO_EN  defined   : fixed priority, M0 wins every tie.
//                      undefined : round-robin against the last-served master.
//
// Ports:
//   CLK, RST                  clock (rising edge), async active-low reset
//   m0_req/we/addr/wd         M0 request inputs
//   m0_ack/err/rd             M0 completion outputs
//   m1_*                      same as M0, for M1
//   bus_addr/bus_wd/bus_we    to the bridge (CPU_Addr, CPU_WD, DEV_WE)
//   bus_rd                    from the bridge (CPU_RD, combinational)
//   busy                      high in XFER and RESP
//   owner                     master of current or last transaction (0 = M0)
//   dbg_state                 FSM state (0 = IDLE, 1 = XFER, 2 = RESP)
// -----------------------------------------------------------------------------
module dev_bus_arbiter #(
   parameter logic [31:0] DEV_BASE  = 32'h0000_7F00,
   parameter logic [31:0] DEV_LAST  = 32'h0000_7F43,
   parameter logic [31:0] NO_HIT_RD = 32'hFFFF_FFFF
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wd,
   output logic        m0_ack,
   output logic        m0_err,
   output logic [31:0] m0_rd,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wd,
   output logic        m1_ack,
   output logic        m1_err,
   output logic [31:0] m1_rd,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wd,
   output logic        bus_we,
   input  logic [31:0] bus_rd,
   output logic        busy,
   output logic        owner,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_XFER = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next_state;

   logic        r_owner;
   logic [31:0] r_addr;
   logic [31:0] r_wd;
   logic        r_we;
   logic        r_in_range;
   logic [31:0] r_m0_rd;
   logic [31:0] r_m1_rd;

   logic        w_any_req;
   logic        w_grant;
   logic [31:0] w_sel_addr;
   logic        w_sel_in_range;
   logic [31:0] w_capture;

   assign w_any_req = m0_req | m1_req;

   // -------------------------------------------------------------------------
   // Arbitration: a lone requester always wins; a tie is broken either by
   // fixed priority or against the last-served master.
   // -------------------------------------------------------------------------
`ifdef ARB_FIXED_PRIO_EN
   always_comb begin
      w_grant = 1'b0;
      if (!m0_req && m1_req)
         w_grant = 1'b1;
   end
`else
   // Reset value 1 makes M0 win the first tie.
   logic r_last;

   always_comb begin
      w_grant = 1'b0;
      if (m0_req && m1_req)
         w_grant = ~r_last;
      else if (m1_req)
         w_grant = 1'b1;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         r_last <= 1'b1;
      else if (r_state == S_RESP)
         r_last <= r_owner;
   end
`endif

   assign w_sel_addr     = w_grant ? m1_addr : m0_addr;
   assign w_sel_in_range = (w_sel_addr >= DEV_BASE) && (w_sel_addr <= DEV_LAST);

   // Writes capture bus_rd too; the bridge's read value is simply reported.
   assign w_capture = r_in_range ? bus_rd : NO_HIT_RD;

   // -------------------------------------------------------------------------
   // FSM
   // -------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         r_state <= S_IDLE;
      else
         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      bus_we       = 1'b0;
      m0_ack       = 1'b0;
      m1_ack       = 1'b0;
      m0_err       = 1'b0;
      m1_err       = 1'b0;
      busy         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any_req)
               w_next_state = S_XFER;
         end
         S_XFER: begin
            busy         = 1'b1;
            // Out-of-window writes never reach the bridge.
            bus_we       = r_we & r_in_range;
            w_next_state = S_RESP;
         end
         S_RESP: begin
            busy         = 1'b1;
            m0_ack       = ~r_owner;
            m1_ack       = r_owner;
            m0_err       = ~r_owner & ~r_in_range;
            m1_err       = r_owner & ~r_in_range;
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Datapath: latch the winner at the grant edge; the latched copy drives the
   // bus so requesters may drop req mid-transaction. Read data goes straight
   // into the owner's result register at the XFER exit edge, so it is valid
   // with the ack and held until that master's next ack.
   // -------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_owner    <= 1'b0;
         r_addr     <= '0;
         r_wd       <= '0;
         r_we       <= 1'b0;
         r_in_range <= 1'b0;
         r_m0_rd    <= '0;
         r_m1_rd    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_owner    <= w_grant;
                  r_addr     <= w_sel_addr;
                  r_wd       <= w_grant ? m1_wd : m0_wd;
                  r_we       <= w_grant ? m1_we : m0_we;
                  r_in_range <= w_sel_in_range;
               end
            end
            S_XFER: begin
               if (r_owner)
                  r_m1_rd <= w_capture;
               else
                  r_m0_rd <= w_capture;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus_addr  = r_addr;
   assign bus_wd    = r_wd;
   assign owner     = r_owner;
   assign m0_rd     = r_m0_rd;
   assign m1_rd     = r_m1_rd;
   assign dbg_state = r_state;

endmodule

// File: doc/dev_bus_arbiter.md
Name: dev_bus_arbiter

Overview:
- Shares the single device-bus port of the peripheral bridge between two requesters:
  - M0: CPU memory stage.
  - M1: debug loader / DMA engine.
- Serializes requests, drives the bridge's address, write-data and write-enable inputs, and captures read data.
- Returns a one-cycle ack with read data and an out-of-window error flag.
- Sits between the CPU/loader and the bridge; the bridge sees one master.

Parameters:
- DEV_BASE, 32'h0000_7F00, lowest valid device byte address (inclusive).
- DEV_LAST, 32'h0000_7F43, highest valid device byte address (inclusive).
- NO_HIT_RD, 32'hFFFF_FFFF, read data returned for out-of-window accesses.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- m0_req  in  1  M0 transaction request; held until m0_ack.
- m0_we  in  1  M0 write (1) / read (0).
- m0_addr  in  32  M0 byte address.
- m0_wd  in  32  M0 write data.
- m0_ack  out  1  one-cycle completion pulse for M0.
- m0_err  out  1  M0 address outside window; valid with m0_ack.
- m0_rd  out  32  M0 read data; valid with m0_ack, held until next M0 ack.
- m1_req, m1_we, m1_addr, m1_wd, m1_ack, m1_err, m1_rd: same as M0, for M1.
- bus_addr  out  32  to bridge CPU_Addr.
- bus_wd  out  32  to bridge CPU_WD.
- bus_we  out  1  to bridge DEV_WE.
- bus_rd  in  32  from bridge CPU_RD (combinational).
- busy  out  1  high in XFER and RESP.
- owner  out  1  requester of current or last transaction (0 = M0, 1 = M1).

Behaviour:
- Reset (RST=0, async): state IDLE; all outputs 0; last-served pointer = 1, so M0 wins the first tie. A transaction in flight is dropped with no ack; bus_we falls immediately.
- FSM states: IDLE, XFER, RESP.
- IDLE:
  - If any req is high at a rising edge, select the winner.
  - Latch its addr/wd/we into internal registers; set owner.
  - Compute in_range = (DEV_BASE <= addr <= DEV_LAST), full 32-bit unsigned compare.
  - Go to XFER.
  - No req: stay in IDLE.
  - bus_we=0 in IDLE; bus_addr/bus_wd hold their last values.
- XFER (exactly 1 cycle):
  - bus_addr/bus_wd = latched values; bus_we = latched_we & in_range.
  - On the exiting edge, capture rd_reg = in_range ? bus_rd : NO_HIT_RD. Writes also capture bus_rd.
  - Go to RESP.
- RESP (1 cycle):
  - Owner's ack=1; owner's err = ~in_range; owner's rd is updated from rd_reg.
  - The other master's ack stays 0 and its rd is unchanged.
  - Last-served pointer = owner. Go to IDLE.
- Timing: req first sampled at edge E0 → bus_we high during E0–E1 → ack high during E1–E2. Next arbitration at E3 or later.
  - Minimum 3 cycles per transaction; peak throughput 1 transaction / 3 cycles.
- Arbitration (default): round-robin.
  - Single requester: granted.
  - Both requesting: grant the master not equal to last-served.
  - Requests arriving during XFER/RESP wait; none are lost while req is held.
- Requester rules:
  - Must hold req/addr/wd/we stable from assertion until ack.
  - May drop req or present a new request on the edge after ack.
  - Request dropped mid-transaction: the transaction still completes and ack still pulses (latched copy used).
- Out-of-window access:
  - Write: no bus_we.
  - Read: returns NO_HIT_RD.
  - Both: err=1 with ack; same 3-cycle timing.
- Address LSBs and alignment are passed unchanged; the bridge decodes them.

Optional Feature:
- ARB_FIXED_PRIO_EN defined: fixed priority, M0 always wins when both request. M1 can starve while m0_req stays asserted. Last-served pointer is unused.
- ARB_FIXED_PRIO_EN undefined: round-robin as above.

Test Plan:
- Reset: drive RST=0 mid-sim with both reqs high → all outputs 0 immediately. After RST=1, first grant goes to M0.
- M0 write 0x7F34, data 0x0000_00FF → bus_we=1 for exactly one cycle with bus_addr=0x7F34, bus_wd=0xFF. m0_ack pulses the next cycle with m0_err=0. m1_ack stays 0.
- M1 read 0x7F40 with bus_rd=0x0000_00A5 → m1_ack with m1_rd=0xA5, m1_err=0, bus_we=0 throughout.
- M0 and M1 reads held continuously for 4 transactions → grants M0, M1, M0, M1, acks 3 cycles apart. With ARB_FIXED_PRIO_EN: M0 ×4, no m1_ack.
- M0 write 0x0000_1000 → no bus_we pulse; m0_ack with m0_err=1, m0_rd=0xFFFF_FFFF. M0 read 0x7F44 → same response.
- RST=0 asserted during XFER of a write → bus_we drops asynchronously. No ack after release; FSM restarts in IDLE and serves a new M1 request normally.
